// File: rtl/cnn_layer_accel_wht_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnn_layer_accel_wht_cfg_pkg
// Shared state encoding and kernel geometry for the weight-table config path.
// Revision: 1.0
// ---------------------------------------------------------------------------
package cnn_layer_accel_wht_cfg_pkg;

  localparam int KERNEL_WORDS = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } wcs_state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_layer_accel_wht_cfg_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnn_layer_accel_wht_cfg_counter
// Nested word/kernel counter with a flag marking the final word of the load.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cnn_layer_accel_wht_cfg_counter
  import cnn_layer_accel_wht_cfg_pkg::*;
#(
  parameter int KERNEL_WORDS_P = KERNEL_WORDS,
  parameter int KRNL_IDX_WIDTH = 6,
  parameter int WORD_CNT_WIDTH = $clog2(KERNEL_WORDS_P)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  input  logic [KRNL_IDX_WIDTH-1:0] last_krnl,
  output logic [WORD_CNT_WIDTH-1:0] word_cnt,
  output logic [KRNL_IDX_WIDTH-1:0] krnl_cnt,
  output logic                      last_word
);

  localparam logic [WORD_CNT_WIDTH-1:0] c_word_last = WORD_CNT_WIDTH'(KERNEL_WORDS_P - 1);

  logic w_word_wrap;

  assign w_word_wrap = (word_cnt == c_word_last);
  // Equality only: a full-range last_krnl must not rely on krnl_cnt+1.
  assign last_word   = w_word_wrap && (krnl_cnt == last_krnl);

  // The final word freezes both counters so krnl_cnt ends on last_krnl.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_cnt <= '0;
      krnl_cnt <= '0;
    end else if (advance && !last_word) begin
      if (w_word_wrap) begin
        word_cnt <= '0;
        krnl_cnt <= krnl_cnt + KRNL_IDX_WIDTH'(1);
      end else begin
        word_cnt <= word_cnt + WORD_CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_layer_accel_weight_config_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnn_layer_accel_weight_config_streamer
// Streams 3x3 kernel weights from a valid/ready source into the weight table.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cnn_layer_accel_weight_config_streamer
  import cnn_layer_accel_wht_cfg_pkg::*;
#(
  parameter int C_KERNEL_WORDS   = KERNEL_WORDS,
  parameter int C_KRNL_IDX_WIDTH = 6,
  parameter int C_DATA_WIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [C_KRNL_IDX_WIDTH-1:0] num_kernels,
  input  logic                        abort,
  input  logic                        wht_in_valid,
  input  logic [C_DATA_WIDTH-1:0]     wht_in_data,
  output logic                        wht_in_ready,
  output logic                        config_mode,
  output logic                        job_accept,
  output logic                        wht_config_wren,
  output logic [C_DATA_WIDTH-1:0]     wht_config_data,
  output logic                        busy,
  output logic                        done
);

  localparam int c_word_cnt_width = $clog2(C_KERNEL_WORDS);

  wcs_state_t                  r_state;
  wcs_state_t                  w_state_nxt;
  logic [C_KRNL_IDX_WIDTH-1:0] r_last_krnl;
  logic [c_word_cnt_width-1:0] w_word_cnt;
  logic [C_KRNL_IDX_WIDTH-1:0] w_krnl_cnt;
  logic                        w_last_word;
  logic                        w_handshake;

  assign w_handshake = wht_in_valid && wht_in_ready;

  cnn_layer_accel_wht_cfg_counter #(
    .KERNEL_WORDS_P (C_KERNEL_WORDS),
    .KRNL_IDX_WIDTH (C_KRNL_IDX_WIDTH),
    .WORD_CNT_WIDTH (c_word_cnt_width)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (r_state == CLEAR),
    .advance   (w_handshake),
    .last_krnl (r_last_krnl),
    .word_cnt  (w_word_cnt),
    .krnl_cnt  (w_krnl_cnt),
    .last_word (w_last_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_krnl <= '0;
    end else if (r_state == IDLE && start) begin
      r_last_krnl <= num_kernels;
    end
  end

  // Abort takes priority over every transition, including the last word.
  always_comb begin
    w_state_nxt = r_state;
    if (abort && r_state != IDLE) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_state_nxt = CLEAR;
        CLEAR:   w_state_nxt = LOAD;
        LOAD:    if (w_handshake && w_last_word) w_state_nxt = FLUSH;
        FLUSH:   w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    wht_in_ready = 1'b0;
    config_mode  = 1'b0;
    job_accept   = 1'b0;
    done         = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      CLEAR: begin
        config_mode = 1'b1;
        job_accept  = 1'b1;
      end
      LOAD: begin
        config_mode  = 1'b1;
        wht_in_ready = 1'b1;
      end
      FLUSH:   config_mode = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // A word accepted on the abort cycle still gets its write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wht_config_wren <= 1'b0;
      wht_config_data <= '0;
    end else begin
      wht_config_wren <= w_handshake;
      if (w_handshake) begin
        wht_config_data <= wht_in_data;
      end
    end
  end

endmodule
`default_nettype wire
